// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Fetches one- or two-word instructions from a word-addressed instruction
// memory and presents them to the decoder with a valid/ready handshake.
// A first word with bit 15 set is followed by one extension word. A jump
// redirects the fetch PC from any state and abandons any read in flight.
//
// Build option:
//   IFETCH_TIMEOUT_EN  When defined, a read that waits 16 consecutive cycles
//                      without i_mem_ready moves the unit to an error state
//                      (o_err=1) until a jump or reset. When undefined,
//                      reads wait indefinitely and o_err is tied to 0.
//
// Parameters:
//   RESET_PC     word address of the first fetch after reset
//
// Ports:
//   i_clk        clock, all state changes on the rising edge
//   i_rst_n      synchronous active-low reset
//   o_mem_addr   instruction memory word address
//   o_mem_rd     memory read request
//   i_mem_rdata  memory read data, valid with i_mem_ready
//   i_mem_ready  read completion for the current request
//   o_ir1        first instruction word
//   o_ir2        extension word (0 for one-word instructions)
//   o_pc         address of the instruction in o_ir1
//   o_valid      o_ir1/o_ir2/o_pc hold a complete instruction
//   i_ready      decoder accepts the instruction while o_valid=1
//   i_jmp        redirect fetch
//   i_jmp_addr   redirect target word address
//   o_err        fetch error flag
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [15:0] o_mem_addr,
  output logic        o_mem_rd,
  input  logic [15:0] i_mem_rdata,
  input  logic        i_mem_ready,
  output logic [15:0] o_ir1,
  output logic [15:0] o_ir2,
  output logic [15:0] o_pc,
  output logic        o_valid,
  input  logic        i_ready,
  input  logic        i_jmp,
  input  logic [15:0] i_jmp_addr,
  output logic        o_err
);

  typedef enum logic [1:0] {
    FETCH1 = 2'd0,
    FETCH2 = 2'd1,
    VALID  = 2'd2,
    ERR    = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] pc_reg,    pc_next;    // fetch PC
  logic [15:0] ir1_reg,   ir1_next;
  logic [15:0] ir2_reg,   ir2_next;
  logic [15:0] opc_reg,   opc_next;   // address of the held instruction
  logic        fetching;
  logic        timeout_hit;

  assign fetching = (state_reg == FETCH1) || (state_reg == FETCH2);

`ifdef IFETCH_TIMEOUT_EN
  logic [3:0] wait_cnt_reg, wait_cnt_next;

  // Counts consecutive waiting cycles of one read. Any completion, jump or
  // state change restarts it; the 16th waiting cycle (count already 15)
  // raises timeout_hit instead of wrapping.
  always_comb begin
    wait_cnt_next = 4'd0;
    timeout_hit   = 1'b0;
    if (!i_jmp && fetching && !i_mem_ready) begin
      if (wait_cnt_reg == 4'd15) begin
        timeout_hit = 1'b1;
      end else begin
        wait_cnt_next = wait_cnt_reg + 4'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wait_cnt_reg <= 4'd0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg <= FETCH1;
      pc_reg    <= RESET_PC;
      ir1_reg   <= 16'h0000;
      ir2_reg   <= 16'h0000;
      opc_reg   <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir1_reg   <= ir1_next;
      ir2_reg   <= ir2_next;
      opc_reg   <= opc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir1_next   = ir1_reg;
    ir2_next   = ir2_reg;
    opc_next   = opc_reg;

    if (i_jmp) begin
      // Jump wins over everything: read data this cycle is dropped and an
      // instruction being handed over in VALID counts as taken.
      state_next = FETCH1;
      pc_next    = i_jmp_addr;
    end else begin
      case (state_reg)
        FETCH1: begin
          if (i_mem_ready) begin
            ir1_next = i_mem_rdata;
            opc_next = pc_reg;
            pc_next  = pc_reg + 16'd1;
            if (i_mem_rdata[15]) begin
              state_next = FETCH2;
            end else begin
              ir2_next   = 16'h0000;
              state_next = VALID;
            end
          end else if (timeout_hit) begin
            state_next = ERR;
          end
        end
        FETCH2: begin
          if (i_mem_ready) begin
            ir2_next   = i_mem_rdata;
            pc_next    = pc_reg + 16'd1;
            state_next = VALID;
          end else if (timeout_hit) begin
            state_next = ERR;
          end
        end
        VALID: begin
          if (i_ready) begin
            state_next = FETCH1;
          end
        end
        ERR: begin
          state_next = ERR;
        end
        default: begin
          state_next = FETCH1;
        end
      endcase
    end
  end

  // The read request is masked while reset is asserted so no request leaks
  // out of a fetch that the reset is about to abandon.
  assign o_mem_rd   = i_rst_n & fetching;
  assign o_mem_addr = i_rst_n ? pc_reg : RESET_PC;
  assign o_ir1      = ir1_reg;
  assign o_ir2      = ir2_reg;
  assign o_pc       = opc_reg;
  assign o_valid    = (state_reg == VALID);

`ifdef IFETCH_TIMEOUT_EN
  assign o_err = (state_reg == ERR);
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch: a 64K-word memory model answers
// combinationally; inputs change and outputs are checked on the falling edge.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [15:0] ir1;
  logic [15:0] ir2;
  logic [15:0] pc;
  logic        valid;
  logic        ready;
  logic        jmp;
  logic [15:0] jmp_addr;
  logic        err;

  logic [15:0] mem [0:65535];

  int checks_cnt = 0;
  int errors_cnt = 0;
  logic timeout_en;

  instruction_fetch #(.RESET_PC(16'h0000)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .o_mem_addr  (mem_addr),
    .o_mem_rd    (mem_rd),
    .i_mem_rdata (mem_rdata),
    .i_mem_ready (mem_ready),
    .o_ir1       (ir1),
    .o_ir2       (ir2),
    .o_pc        (pc),
    .o_valid     (valid),
    .i_ready     (ready),
    .i_jmp       (jmp),
    .i_jmp_addr  (jmp_addr),
    .o_err       (err)
  );

  assign mem_rdata = mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
`ifdef IFETCH_TIMEOUT_EN
    timeout_en = 1'b1;
`else
    timeout_en = 1'b0;
`endif
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0000] = 16'h1234;
    mem[16'h0001] = 16'h0042;
    mem[16'h0004] = 16'h8001;
    mem[16'h0005] = 16'hABCD;
    mem[16'h0010] = 16'h8111;
    mem[16'h0011] = 16'h2222;
    mem[16'hFFFF] = 16'h8000;

    rst_n = 1'b0; mem_ready = 1'b1; ready = 1'b1; jmp = 1'b0; jmp_addr = 16'h0000;
    step(); step();
    check("rst_mem_rd",   {31'd0, mem_rd}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'h0000);
    check("rst_valid",    {31'd0, valid}, 32'd0);
    check("rst_err",      {31'd0, err}, 32'd0);
    check("rst_pc",       {16'd0, pc}, 32'h0000);

    // Reset release: request appears immediately, valid one edge later.
    rst_n = 1'b1;
    #1;
    check("rel_mem_rd",   {31'd0, mem_rd}, 32'd1);
    check("rel_valid",    {31'd0, valid}, 32'd0);
    step();
    check("w1_valid",     {31'd0, valid}, 32'd1);
    check("w1_ir1",       {16'd0, ir1}, 32'h1234);
    check("w1_ir2",       {16'd0, ir2}, 32'h0000);
    check("w1_pc",        {16'd0, pc}, 32'h0000);
    check("w1_mem_rd",    {31'd0, mem_rd}, 32'd0);
    step();
    check("acc_valid",    {31'd0, valid}, 32'd0);
    check("acc_addr",     {16'd0, mem_addr}, 32'h0001);

    // Decoder stall for 5 cycles in VALID.
    ready = 1'b0;
    step();
    check("st_valid",     {31'd0, valid}, 32'd1);
    check("st_ir1",       {16'd0, ir1}, 32'h0042);
    for (int i = 0; i < 5; i++) begin
      step();
      check("st_hold", {ir1, pc}, {16'h0042, 16'h0001});
      check("st_rd",   {30'd0, valid, mem_rd}, {30'd0, 1'b1, 1'b0});
    end
    ready = 1'b1;
    step();
    check("st_rel_valid", {31'd0, valid}, 32'd0);
    check("st_rel_addr",  {16'd0, mem_addr}, 32'h0002);

    // Jump to a two-word instruction; read data during jump cycle dropped.
    jmp = 1'b1; jmp_addr = 16'h0004;
    step();
    jmp = 1'b0;
    check("j4_addr",  {15'd0, mem_rd, mem_addr}, {15'd0, 1'b1, 16'h0004});
    step();
    check("j4_f2",    {15'd0, valid, mem_addr}, {15'd0, 1'b0, 16'h0005});
    step();
    check("j4_ir",    {ir1, ir2}, {16'h8001, 16'hABCD});
    check("j4_pc",    {15'd0, valid, pc}, {15'd0, 1'b1, 16'h0004});
    step();
    check("j4_next",  {16'd0, mem_addr}, 32'h0006);

    // Two-word instruction straddling the top of the address space.
    jmp = 1'b1; jmp_addr = 16'hFFFF;
    step();
    jmp = 1'b0;
    check("wr_addr1", {16'd0, mem_addr}, 32'hFFFF);
    step();
    check("wr_addr2", {16'd0, mem_addr}, 32'h0000);
    step();
    check("wr_ir",    {ir1, ir2}, {16'h8000, 16'h1234});
    check("wr_pc",    {16'd0, pc}, 32'hFFFF);
    step();
    check("wr_next",  {16'd0, mem_addr}, 32'h0001);

    // Stall in FETCH2 then jump.
    jmp = 1'b1; jmp_addr = 16'h0004;
    step();
    jmp = 1'b0;
    step();
    mem_ready = 1'b0;
    step();
    check("f2s_hold", {14'd0, valid, mem_rd, mem_addr}, {14'd0, 1'b0, 1'b1, 16'h0005});
    jmp = 1'b1; jmp_addr = 16'h0010;
    step();
    jmp = 1'b0;
    check("f2s_jmp",  {15'd0, valid, mem_addr}, {15'd0, 1'b0, 16'h0010});

    // Reset in the middle of FETCH2.
    mem_ready = 1'b1;
    step();
    check("f2r_pre",  {16'd0, mem_addr}, 32'h0011);
    rst_n = 1'b0;
    #1;
    check("f2r_comb", {15'd0, mem_rd, mem_addr}, {15'd0, 1'b0, 16'h0000});
    step();
    check("f2r_ir",   {ir1, ir2}, 32'h0000_0000);
    check("f2r_st",   {13'd0, valid, err, mem_rd, pc}, 32'h0000_0000);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    #1;
    check("f2r_rel",  {15'd0, mem_rd, mem_addr}, {15'd0, 1'b1, 16'h0000});

    // Read timeout.
    for (int i = 0; i < 15; i++) step();
    check("to_15",    {30'd0, err, mem_rd}, {30'd0, 1'b0, 1'b1});
    step();
    if (timeout_en)
      check("to_16",  {30'd0, err, mem_rd}, {30'd0, 1'b1, 1'b0});
    else
      check("to_16",  {30'd0, err, mem_rd}, {30'd0, 1'b0, 1'b1});
    jmp = 1'b1; jmp_addr = 16'h0020;
    step();
    jmp = 1'b0;
    check("to_jmp",   {14'd0, err, mem_rd, mem_addr}, {14'd0, 1'b0, 1'b1, 16'h0020});

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
